// File: rtl/usb_gpx_pkg.sv
// Shared constants for the MAX3421E GPX/INT side-band event controller.
package usb_gpx_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_MASK     = 2'd1;
  localparam logic [1:0] ADDR_CAPTURE  = 2'd2;
  localparam logic [1:0] ADDR_EDGE_SEL = 2'd3;

  localparam int FILT_CNT_W = 8;

endpackage

// File: rtl/gpx_input_filter.sv
// One side-band pin: two-flop synchroniser, stability filter and
// a delayed copy of the filtered level for edge detection.
module gpx_input_filter
  import usb_gpx_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_filt,
  output logic o_filt_d
);

  localparam logic [FILT_CNT_W-1:0] LP_LAST =
    FILT_CNT_W'(FILTER_CYCLES - 1);

  logic                  r_s1;
  logic                  r_s2;
  logic                  r_filt;
  logic                  r_filt_d;
  logic [FILT_CNT_W-1:0] r_cnt;
  logic                  w_diff;

  assign w_diff = r_s2 ^ r_filt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_filt   <= 1'b0;
      r_filt_d <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1     <= i_pin;
      r_s2     <= r_s1;
      r_filt_d <= r_filt;
      // any sample agreeing with filt restarts the stability count
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_LAST) begin
        r_filt <= r_s2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_filt   = r_filt;
  assign o_filt_d = r_filt_d;

endmodule

// File: rtl/usb_gpx_event_ctrl.sv
// GPX/INT event controller: filtered pins, edge capture, Avalon-MM
// register file and a single level interrupt.
module usb_gpx_event_ctrl
  import usb_gpx_pkg::*;
#(
  parameter int NUM_IN        = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] in_port,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  logic [NUM_IN-1:0] w_filt;
  logic [NUM_IN-1:0] w_filt_d;
  logic [NUM_IN-1:0] w_rise;
  logic [NUM_IN-1:0] w_fall;
  logic [NUM_IN-1:0] w_event;
  logic [NUM_IN-1:0] w_w1c;
  logic [NUM_IN-1:0] r_mask;
  logic [NUM_IN-1:0] r_cap;
  logic [NUM_IN-1:0] r_edge_sel;
  logic              w_wr;
  logic [31:0]       w_rd_mux;
  logic              w_unused;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_filt
    gpx_input_filter #(
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filt (
      .clk     (clk),
      .reset   (reset),
      .i_pin   (in_port[g]),
      .o_filt  (w_filt[g]),
      .o_filt_d(w_filt_d[g])
    );
  end

  assign w_wr   = chipselect & ~write_n;
  assign w_rise = w_filt & ~w_filt_d;
  assign w_fall = ~w_filt & w_filt_d;
  // polarity only gates an existing transition, so retargeting is glitch-free
  assign w_event = (w_rise & ~r_edge_sel) | (w_fall & r_edge_sel);
  assign w_w1c = (w_wr && address == ADDR_CAPTURE) ?
                 writedata[NUM_IN-1:0] : '0;
  assign w_unused = ^writedata[31:NUM_IN];

  always_comb begin
    w_rd_mux = '0;
    unique case (address)
      ADDR_DATA:     w_rd_mux[NUM_IN-1:0] = w_filt;
      ADDR_MASK:     w_rd_mux[NUM_IN-1:0] = r_mask;
      ADDR_CAPTURE:  w_rd_mux[NUM_IN-1:0] = r_cap;
      ADDR_EDGE_SEL: w_rd_mux[NUM_IN-1:0] = r_edge_sel;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask     <= '0;
      r_cap      <= '0;
      r_edge_sel <= '0;
      readdata   <= '0;
      irq        <= 1'b0;
    end else begin
      // a new event outranks a same-cycle clear
      r_cap    <= (r_cap & ~w_w1c) | w_event;
      readdata <= w_rd_mux;
      irq      <= |(r_cap & r_mask);
      if (w_wr && address == ADDR_MASK)
        r_mask <= writedata[NUM_IN-1:0];
      if (w_wr && address == ADDR_EDGE_SEL)
        r_edge_sel <= writedata[NUM_IN-1:0];
    end
  end

endmodule

// File: tb/tb_usb_gpx_event_ctrl.sv
// Self-checking bench for usb_gpx_event_ctrl: directed sequences
// plus randomized traffic against a window-based reference model.
module tb_usb_gpx_event_ctrl;

  localparam int N  = 2;
  localparam int FC = 4;

  logic          clk        = 1'b0;
  logic          reset      = 1'b1;
  logic [N-1:0]  in_port    = '0;
  logic [1:0]    address    = '0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = '0;
  logic [31:0]   readdata;
  logic          irq;

  int n_chk  = 0;
  int n_fail = 0;

  usb_gpx_event_ctrl #(
    .NUM_IN(N),
    .FILTER_CYCLES(FC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_port   (in_port),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [N-1:0] m_s1, m_s2, m_filt, m_fd;
  logic [N-1:0] m_cap, m_mask, m_es;
  logic         m_irq;
  logic [31:0]  m_rd;
  logic [N-1:0] m_hist[$];

  // filt flips once the last FC synchronised samples all disagree with it
  task automatic model_step();
    logic [N-1:0] nf, ev, w1c, h;
    logic         all_diff;
    logic [31:0]  rd;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_filt = '0; m_fd = '0;
      m_cap = '0; m_mask = '0; m_es = '0;
      m_irq = 1'b0; m_rd = '0;
      m_hist.delete();
      repeat (FC) m_hist.push_back('0);
    end else begin
      m_hist.push_back(m_s2);
      void'(m_hist.pop_front());
      nf = m_filt;
      for (int b = 0; b < N; b++) begin
        all_diff = 1'b1;
        foreach (m_hist[k]) begin
          h = m_hist[k];
          if (h[b] == m_filt[b]) all_diff = 1'b0;
        end
        if (all_diff) nf[b] = ~m_filt[b];
      end
      ev = (m_filt & ~m_fd & ~m_es) | (~m_filt & m_fd & m_es);
      rd = '0;
      case (address)
        2'd0:    rd[N-1:0] = m_filt;
        2'd1:    rd[N-1:0] = m_mask;
        2'd2:    rd[N-1:0] = m_cap;
        default: rd[N-1:0] = m_es;
      endcase
      m_rd  = rd;
      m_irq = |(m_cap & m_mask);
      w1c = '0;
      if (chipselect && !write_n) begin
        case (address)
          2'd1:    m_mask = writedata[N-1:0];
          2'd2:    w1c = writedata[N-1:0];
          2'd3:    m_es = writedata[N-1:0];
          default: ;
        endcase
      end
      m_cap  = (m_cap & ~w1c) | ev;
      m_fd   = m_filt;
      m_filt = nf;
      m_s2   = m_s1;
      m_s1   = in_port;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a,
                        input logic [31:0] exp);
    address = a;
    tick(1);
    check(name, readdata, exp);
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t rv[4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      rv[i].addr    = 2'(i);
      rv[i].exp_rd  = 32'h0;
      rv[i].exp_irq = 1'b0;
    end

    // reset state and reads of every register
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      address = rv[i].addr;
      tick(1);
      check($sformatf("rst_rd_a%0d", i), readdata, rv[i].exp_rd);
      check($sformatf("rst_irq_a%0d", i), {31'h0, irq},
            {31'h0, rv[i].exp_irq});
    end

    // clean rising step on bit0 with irq enabled
    wr(2'd1, 32'h1);
    in_port = 2'b01;
    address = 2'd0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i == 6) check("data_before_filt", readdata, 32'h0);
      if (i == 7) begin
        check("data_bit0", readdata, 32'h1);
        check("irq_before_cap", {31'h0, irq}, 32'h0);
      end
      if (i == 8) check("irq_after_cap", {31'h0, irq}, 32'h1);
    end
    rd_chk("cap_rise0", 2'd2, 32'h1);

    // 3-cycle glitch on bit1 must be rejected
    in_port = 2'b11;
    tick(3);
    in_port = 2'b01;
    tick(10);
    rd_chk("glitch_data", 2'd0, 32'h1);
    rd_chk("glitch_cap", 2'd2, 32'h1);

    // falling polarity on bit1, then W1C and irq release
    wr(2'd3, 32'h2);
    in_port = 2'b11;
    tick(10);
    rd_chk("rise_ignored", 2'd2, 32'h1);
    wr(2'd2, 32'h1);
    wr(2'd1, 32'h3);
    in_port = 2'b01;
    tick(10);
    rd_chk("cap_fall1", 2'd2, 32'h2);
    check("irq_fall1", {31'h0, irq}, 32'h1);
    wr(2'd2, 32'h2);
    check("irq_hold_on_clear", {31'h0, irq}, 32'h1);
    tick(1);
    check("irq_drop", {31'h0, irq}, 32'h0);
    rd_chk("cap_cleared", 2'd2, 32'h0);

    // clear and new event on the same bit in the same cycle
    in_port = 2'b00;
    tick(10);
    rd_chk("cap_before_race", 2'd2, 32'h0);
    in_port = 2'b01;
    tick(6);
    wr(2'd2, 32'h1);
    rd_chk("set_wins", 2'd2, 32'h1);

    // reset partway through filtering with the pin held high
    in_port = 2'b00;
    tick(10);
    in_port = 2'b01;
    tick(4);
    address = 2'd2;
    reset   = 1'b1;
    tick(2);
    check("inrst_readdata", readdata, 32'h0);
    check("inrst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i == 7) check("post_rst_pre", readdata, 32'h0);
      if (i == 8) check("post_rst_cap", readdata, 32'h1);
    end

    // randomized traffic against the reference model
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 4) == 0)
        in_port = in_port ^ (N'(1) << $urandom_range(0, N - 1));
      chipselect = ($urandom_range(0, 3) == 0);
      write_n    = 1'($urandom_range(0, 1));
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      reset      = ($urandom_range(0, 399) == 0);
      tick(1);
      check("rand_readdata", readdata, m_rd);
      check("rand_irq", {31'h0, irq}, {31'h0, m_irq});
    end
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
